fir_out_checker: RTL

Self-checking response monitor for the 9-tap FIR datapath. It is the consuming end of the stimulus/response pair: it sees the same in_data stream the stimulus generator drives into the filter and a golden copy of the coefficients, and computes the expected output with its own model. It aligns that result to the DUT latency, compares it against filter_output, and reports a pass/fail verdict, error counts and the first mismatch. It sits beside the filter in the on-board test top, so results can be read on hardware.

---
 rtl/fir_pkg.sv | 18 +
 rtl/fir_golden.sv | 32 +++
 rtl/fir_out_checker.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared widths and FSM encoding for the FIR response checker and its golden model.
package fir_pkg;

    localparam int NTAPS   = 9;
    localparam int DATA_W  = 8;
    localparam int COEFF_W = 8;
    localparam int OUT_W   = 24;
    localparam int SUM_W   = 20;
    localparam int PROD_W  = DATA_W + COEFF_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/fir_golden.sv
// Golden 9-tap FIR model: registered tap line plus an exact, untruncated combinational sum.
module fir_golden
    import fir_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_W-1:0]              in_data,
    input  logic [NTAPS-1:0][COEFF_W-1:0]  coeff,
    output logic [SUM_W-1:0]               sum
);

    logic [NTAPS-1:0][DATA_W-1:0] taps_p0;

    // taps_p0[k] holds x(t-k) relative to the newest registered sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            taps_p0 <= '0;
        end else begin
            taps_p0 <= {taps_p0[NTAPS-2:0], in_data};
        end
    end

    always_comb begin
        logic [PROD_W-1:0] prod;
        sum = '0;
        for (int k = 0; k < NTAPS; k++) begin
            prod = PROD_W'(taps_p0[k]) * PROD_W'(coeff[k]);
            sum  = sum + SUM_W'(prod);
        end
    end

endmodule

// File: rtl/fir_out_checker.sv
// Response checker for the 9-tap FIR: golden model, latency alignment, compare FSM and result capture.
module fir_out_checker
    import fir_pkg::*;
#(
    parameter int LATENCY     = 1,
    parameter int WARMUP      = 9,
    parameter int NUM_SAMPLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [COEFF_W-1:0]  coeff_a00,
    input  logic [COEFF_W-1:0]  coeff_a01,
    input  logic [COEFF_W-1:0]  coeff_a02,
    input  logic [COEFF_W-1:0]  coeff_a03,
    input  logic [COEFF_W-1:0]  coeff_a04,
    input  logic [COEFF_W-1:0]  coeff_a05,
    input  logic [COEFF_W-1:0]  coeff_a06,
    input  logic [COEFF_W-1:0]  coeff_a07,
    input  logic [COEFF_W-1:0]  coeff_a08,
    input  logic [OUT_W-1:0]    filter_output,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         sample_count,
    output logic [15:0]         err_count,
    output logic [15:0]         first_err_idx,
    output logic [OUT_W-1:0]    first_err_exp,
    output logic [OUT_W-1:0]    first_err_got
);

    localparam int CNT_W = 16;
    localparam int DLY_N = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_SAMPLES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    logic [NTAPS-1:0][COEFF_W-1:0] coeff;
    logic [SUM_W-1:0]              sum_p0;
    logic [SUM_W-1:0]              exp_sum;
    logic [OUT_W-1:0]              exp_val;
    logic                          mismatch;

    assign coeff = {coeff_a08, coeff_a07, coeff_a06, coeff_a05, coeff_a04,
                    coeff_a03, coeff_a02, coeff_a01, coeff_a00};

    fir_golden u_golden (
        .clk     (clk),
        .rst     (rst),
        .in_data (in_data),
        .coeff   (coeff),
        .sum     (sum_p0)
    );

    // The tap register already supplies one cycle, so LATENCY 0 and 1 both use the sum directly
    generate
        if (LATENCY > 1) begin : g_dly
            logic [DLY_N-1:0][SUM_W-1:0] dly_p1;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dly_p1 <= '0;
                end else begin
                    dly_p1[0] <= sum_p0;
                    for (int i = 1; i < DLY_N; i++) begin
                        dly_p1[i] <= dly_p1[i-1];
                    end
                end
            end
            assign exp_sum = dly_p1[DLY_N-1];
        end else begin : g_nodly
            assign exp_sum = sum_p0;
        end
    endgenerate

    assign exp_val  = OUT_W'(exp_sum);
    assign mismatch = (exp_val != filter_output);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    warm_cnt, warm_nxt;
    logic [CNT_W-1:0]    sample_nxt, err_nxt, fidx_nxt;
    logic [OUT_W-1:0]    fexp_nxt, fgot_nxt;

    always_comb begin
        state_nxt  = state;
        warm_nxt   = warm_cnt;
        sample_nxt = sample_count;
        err_nxt    = err_count;
        fidx_nxt   = first_err_idx;
        fexp_nxt   = first_err_exp;
        fgot_nxt   = first_err_got;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt  = (WARMUP == 0) ? S_CHECK : S_WARMUP;
                    warm_nxt   = '0;
                    sample_nxt = '0;
                    err_nxt    = '0;
                    fidx_nxt   = '0;
                    fexp_nxt   = '0;
                    fgot_nxt   = '0;
                end
            end
            S_WARMUP: begin
                if (warm_cnt == WARM_LAST) state_nxt = S_CHECK;
                else                       warm_nxt  = warm_cnt + CNT_W'(1);
            end
            S_CHECK: begin
                sample_nxt = sample_count + CNT_W'(1);
                if (mismatch) begin
                    err_nxt = sat_inc(err_count);
                    if (err_count == '0) begin
                        fidx_nxt = sample_count;
                        fexp_nxt = exp_val;
                        fgot_nxt = filter_output;
                    end
                end
                if (sample_nxt == LAST_CNT) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status flags are registered from the next-state view so they line up with the counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            warm_cnt      <= '0;
            sample_count  <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            state         <= state_nxt;
            warm_cnt      <= warm_nxt;
            sample_count  <= sample_nxt;
            err_count     <= err_nxt;
            first_err_idx <= fidx_nxt;
            first_err_exp <= fexp_nxt;
            first_err_got <= fgot_nxt;
            busy          <= (state_nxt == S_WARMUP) || (state_nxt == S_CHECK);
            done          <= (state_nxt == S_DONE);
            pass          <= (state_nxt == S_DONE) && (err_nxt == '0);
        end
    end

endmodule
